// File: rtl/cacc_final_pack_pkg.sv
// Shared types and constants for the CACC final-result packer.
//   DATA_W      : width of one final result from the calc cell
//   PACK        : results per delivery-buffer entry (power of 2, >= 2)
//   IDX_W       : lane index width
//   pack_entry_t: one packed delivery-buffer entry (data + lane-valid mask)
package cacc_final_pack_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PACK   = 4;
  localparam int unsigned IDX_W  = $clog2(PACK);

  typedef struct packed {
    logic [PACK*DATA_W-1:0] data;
    logic [PACK-1:0]        mask;
  } pack_entry_t;

endpackage

// File: rtl/cacc_final_fifo.sv
// Synchronous FIFO of packed entries between the packer and the dbuf write port.
// The head is taken straight from the storage flops, so the write port sees no
// combinational path from the packer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear; a push in the same cycle lands in the emptied FIFO
//   push       : write wr_entry (ignored when full unless a pop happens this cycle)
//   wr_entry   : entry to write
//   pop        : remove the head entry
//   head       : current head entry (zero while empty)
//   full/empty : occupancy flags
module cacc_final_fifo
  import cacc_final_pack_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  pack_entry_t wr_entry,
  input  logic        pop,
  output pack_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  pack_entry_t         mem_q [Depth];
  logic [PtrW-1:0]     rd_q, rd_d, wr_q, wr_d, wr_base;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                pop_ok, push_ok;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntW'(Depth));
  assign head  = empty ? '0 : mem_q[rd_q];

  // Clear wins over pop; a push after clear always has room.
  assign pop_ok  = pop & ~empty & ~clr;
  assign push_ok = push & (clr | ~full | pop_ok);
  assign wr_base = clr ? '0 : wr_q;

  always_comb begin
    rd_d  = clr ? '0 : rd_q;
    wr_d  = wr_base;
    cnt_d = clr ? '0 : cnt_q;
    if (pop_ok) begin
      rd_d  = next_ptr(rd_d);
      cnt_d = cnt_d - 1'b1;
    end
    if (push_ok) begin
      wr_d  = next_ptr(wr_d);
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push_ok) begin
        mem_q[wr_base] <= wr_entry;
      end
    end
  end

endmodule

// File: rtl/cacc_final_pack.sv
// Packs PACK consecutive final results from the CACC calc cell into one dbuf
// write entry, buffers entries in a small FIFO against dbuf backpressure, and
// counts saturated results per layer.
// Optional feature macro: CACC_FINAL_SAT_CNT_EN builds the saturation counter;
// without it sat_count is tied to 0 and in_final_sat is ignored.
// Ports:
//   nvdla_core_clk, nvdla_core_rstn : clock, asynchronous active-low reset
//   in_final_valid/data/sat         : per-cycle final result (cannot be stalled)
//   layer_start                     : clear all layer state (pack, FIFO, addr, counters)
//   layer_end                       : flush a partially filled pack
//   dlv_wr_valid/ready/addr/data/mask : dbuf write port, lane 0 in data LSBs
//   sat_count                       : saturated results this layer (saturating)
//   ovf_err                         : sticky, a packed entry was dropped on a full FIFO
//   busy                            : pack partially filled or FIFO non-empty
module cacc_final_pack
  import cacc_final_pack_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DBUF_ENTRIES = 512
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   in_final_valid,
  input  logic [DATA_W-1:0]      in_final_data,
  input  logic                   in_final_sat,
  input  logic                   layer_start,
  input  logic                   layer_end,
  output logic                   dlv_wr_valid,
  input  logic                   dlv_wr_ready,
  output logic [ADDR_W-1:0]      dlv_wr_addr,
  output logic [PACK*DATA_W-1:0] dlv_wr_data,
  output logic [PACK-1:0]        dlv_wr_mask,
  output logic [31:0]            sat_count,
  output logic                   ovf_err,
  output logic                   busy
);

  logic [IDX_W-1:0]       idx_q, idx_d, idx_base;
  logic [PACK*DATA_W-1:0] data_q, data_d, data_base, fill_data;
  logic [PACK-1:0]        mask_q, mask_d, mask_base, fill_mask;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   ovf_q, ovf_d;
  logic                   push, pop, drop;
  logic                   fifo_full, fifo_empty;
  pack_entry_t            push_entry, head;

  // Pack register: layer_start clears first, then the sample (if any) is
  // written, then completion or flush pushes exactly once.
  always_comb begin
    idx_base  = layer_start ? '0 : idx_q;
    data_base = layer_start ? '0 : data_q;
    mask_base = layer_start ? '0 : mask_q;
    fill_data = data_base;
    fill_mask = mask_base;
    if (in_final_valid) begin
      fill_data[idx_base*DATA_W +: DATA_W] = in_final_data;
      fill_mask[idx_base]                  = 1'b1;
    end
    push = (in_final_valid & (idx_base == IDX_W'(PACK - 1)))
         | (layer_end & (in_final_valid | (idx_base != '0)));
    // PACK is a power of 2, so the lane index wraps on its own.
    idx_d  = in_final_valid ? idx_base + 1'b1 : idx_base;
    data_d = fill_data;
    mask_d = fill_mask;
    if (push) begin
      idx_d  = '0;
      data_d = '0;
      mask_d = '0;
    end
  end

  assign push_entry = '{data: fill_data, mask: fill_mask};

  cacc_final_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .clr      (layer_start),
    .push     (push),
    .wr_entry (push_entry),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign dlv_wr_valid = ~fifo_empty;
  assign dlv_wr_data  = head.data;
  assign dlv_wr_mask  = head.mask;
  assign dlv_wr_addr  = addr_q;
  assign pop          = dlv_wr_valid & dlv_wr_ready;
  assign busy         = (idx_q != '0) | ~fifo_empty;
  assign ovf_err      = ovf_q;

  // Same-cycle pop frees a slot, so only a push to a full FIFO without pop drops.
  assign drop = push & fifo_full & ~pop & ~layer_start;

  always_comb begin
    addr_d = addr_q;
    if (layer_start) begin
      addr_d = '0;
    end else if (pop) begin
      addr_d = (addr_q == ADDR_W'(DBUF_ENTRIES - 1)) ? '0 : addr_q + 1'b1;
    end
    ovf_d = layer_start ? 1'b0 : (ovf_q | drop);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      idx_q  <= '0;
      data_q <= '0;
      mask_q <= '0;
      addr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
      mask_q <= mask_d;
      addr_q <= addr_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef CACC_FINAL_SAT_CNT_EN
  logic [31:0] sat_q, sat_d;

  // Saturating counter: holds at all-ones instead of wrapping.
  always_comb begin
    sat_d = layer_start ? '0 : sat_q;
    if (in_final_valid && in_final_sat && (sat_d != '1)) begin
      sat_d = sat_d + 32'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      sat_q <= '0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_count = sat_q;
`else
  logic unused_sat;
  assign unused_sat = in_final_sat;
  assign sat_count  = '0;
`endif

endmodule
